// File: rtl/booth_r4_pkg.sv
// Shared types for the radix-4 Booth multiplier.
//   booth_state_t : control FSM states
//   booth_op_t    : recoded partial-product selection
//   booth_decode  : maps a Booth triplet {q[i+1], q[i], q[i-1]} to its operation
package booth_r4_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } booth_state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } booth_op_t;

  // Modified Booth recoding table.
  function automatic booth_op_t booth_decode(input logic [2:0] triplet);
    booth_op_t op;
    case (triplet)
      3'b001, 3'b010: op = PM;
      3'b011:         op = P2M;
      3'b100:         op = N2M;
      3'b101, 3'b110: op = NM;
      default:        op = ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_r4_multiplier_if.sv
// Start/ready/done control and operand/result bus of the Booth multiplier.
//   master : launches operations (start, signed_mode, m_in, q_in)
//   slave  : the multiplier (result, ready, done)
interface booth_r4_multiplier_if
  import booth_r4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                      start;
  logic                      signed_mode;
  logic [DATA_WIDTH-1:0]     m_in;
  logic [DATA_WIDTH-1:0]     q_in;
  logic [2*DATA_WIDTH-1:0]   result;
  logic                      ready;
  logic                      done;

  modport master (
    output start, signed_mode, m_in, q_in,
    input  result, ready, done
  );

  modport slave (
    input  start, signed_mode, m_in, q_in,
    output result, ready, done
  );

endinterface

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: selects 0, +-M or +-2M as a signed addend.
//   triplet  : {Q[1], Q[0], q[-1]}
//   m_ext    : extended multiplicand (EXT bits, two's complement)
//   addend_c : signed addend, EXT+2 bits so that +-2M cannot overflow
module booth_r4_recoder
  import booth_r4_pkg::*;
#(
  parameter int unsigned EXT = 18
) (
  input  logic [2:0]     triplet,
  input  logic [EXT-1:0] m_ext,
  output logic [EXT+1:0] addend_c
);

  localparam int unsigned AW = EXT + 2;

  logic [AW-1:0] m_sx;
  logic [AW-1:0] m_x2;

  // Sign-extend M to the accumulator width, then form 2M by a left shift.
  always_comb begin
    m_sx     = {{2{m_ext[EXT-1]}}, m_ext};
    m_x2     = {m_sx[AW-2:0], 1'b0};
    addend_c = '0;
    case (booth_decode(triplet))
      PM:      addend_c = m_sx;
      P2M:     addend_c = m_x2;
      NM:      addend_c = ~m_sx + AW'(1);
      N2M:     addend_c = ~m_x2 + AW'(1);
      default: addend_c = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier, two multiplier bits per cycle.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus.start, bus.signed_mode, bus.m_in, bus.q_in : launch request and operands
//   bus.result : product of the last completed operation (held)
//   bus.ready  : idle, start accepted
//   bus.done   : one-cycle strobe when result updates
module booth_r4_multiplier
  import booth_r4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  booth_r4_multiplier_if.slave   bus
);

  localparam int unsigned EXT = DATA_WIDTH + 2;
  localparam int unsigned AW  = EXT + 2;
  localparam int unsigned N   = EXT / 2;
  localparam int unsigned CW  = $clog2(N + 1);
  localparam int unsigned PW  = 2 * DATA_WIDTH;

  if ((DATA_WIDTH < 4) || ((DATA_WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth_r4_multiplier: DATA_WIDTH must be even and >= 4");
  end

  booth_state_t      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     a_q, a_d;
  logic [EXT-1:0]    q_q, q_d;
  logic              qm1_q, qm1_d;
  logic [EXT-1:0]    m_q, m_d;
  logic [PW-1:0]     result_q, result_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              accept_c;
  logic [AW-1:0]     addend_c;
  logic [AW-1:0]     a_sum_c;

  booth_r4_recoder #(
    .EXT (EXT)
  ) u_recoder (
    .triplet  ({q_q[1:0], qm1_q}),
    .m_ext    (m_q),
    .addend_c (addend_c)
  );

  assign accept_c = (state_q == IDLE) && ready_q && bus.start;
  assign a_sum_c  = a_q + addend_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = CALC;
      CALC:    if (cnt_q == CW'(N - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; ready is withheld for the cycle in which done is shown.
  always_comb begin
    result_d = result_q;
    done_d   = (state_q == DONE);
    ready_d  = (state_d == IDLE) && (state_q != DONE);
    if (state_q == DONE) begin
      result_d = {a_q[PW-EXT-1:0], q_q};
    end
  end

  // Datapath: load on accept, one add-and-shift step per CALC cycle.
  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    q_d   = q_q;
    qm1_d = qm1_q;
    m_d   = m_q;
    if (accept_c) begin
      cnt_d = '0;
      a_d   = '0;
      qm1_d = 1'b0;
      m_d   = {{2{bus.m_in[DATA_WIDTH-1] & bus.signed_mode}}, bus.m_in};
      q_d   = {{2{bus.q_in[DATA_WIDTH-1] & bus.signed_mode}}, bus.q_in};
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + CW'(1);
      // Arithmetic shift of {A, Q, q[-1]} right by two.
      a_d   = {{2{a_sum_c[AW-1]}}, a_sum_c[AW-1:2]};
      q_d   = {a_sum_c[1:0], q_q[EXT-1:2]};
      qm1_d = q_q[1];
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Directed bench for booth_r4_multiplier at DATA_WIDTH=16.
module tb_booth_r4_multiplier;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  booth_r4_multiplier_if #(.DATA_WIDTH(W)) bus_if ();

  booth_r4_multiplier #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int   checks   = 0;
  int   errors   = 0;
  int   n_ops    = 0;
  int   done_cnt = 0;
  int   viol     = 0;
  logic prev_done = 1'b0;

  // Protocol monitor: counts done pulses, flags back-to-back done and ready&&done.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus_if.done === 1'b1) done_cnt++;
      if (bus_if.done === 1'b1 && prev_done === 1'b1) viol++;
      if (bus_if.done === 1'b1 && bus_if.ready === 1'b1) viol++;
      prev_done = bus_if.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present operands just after an edge; returns just after the sampling edge
  // with the inputs scrambled so that only latched values can matter.
  task automatic launch(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q);
    @(posedge clk); #1;
    bus_if.start       = 1'b1;
    bus_if.signed_mode = sm;
    bus_if.m_in        = m;
    bus_if.q_in        = q;
    @(posedge clk); #1;
    bus_if.start       = 1'b0;
    bus_if.signed_mode = ~sm;
    bus_if.m_in        = ~m;
    bus_if.q_in        = q ^ 16'h5A5A;
  endtask

  // Wait (bounded) for done; check latency, result and ready/done framing.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int lat;
    lat = 0;
    do begin
      check({tag, " busy_ready"}, 32'(bus_if.ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end while (bus_if.done !== 1'b1 && lat < 40);
    n_ops++;
    check({tag, " latency"}, 32'(lat), 32'd10);
    check({tag, " result"}, bus_if.result, exp);
    check({tag, " ready_at_done"}, 32'(bus_if.ready), 32'd0);
    @(posedge clk); #1;
    check({tag, " done_cleared"}, 32'(bus_if.done), 32'd0);
    check({tag, " ready_back"}, 32'(bus_if.ready), 32'd1);
    check({tag, " result_held"}, bus_if.result, exp);
  endtask

  initial begin
    int          lat;
    int          done_before;
    logic        sm;
    logic [W-1:0] m, q;
    logic [31:0] exp;

    rst_n              = 1'b0;
    bus_if.start       = 1'b0;
    bus_if.signed_mode = 1'b0;
    bus_if.m_in        = '0;
    bus_if.q_in        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", bus_if.result, 32'h0);
    check("reset ready", 32'(bus_if.ready), 32'd1);
    check("reset done", 32'(bus_if.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    launch(1'b0, 16'hFFFF, 16'hFFFF);  wait_done("u_ffff_ffff", 32'hFFFE0001);
    launch(1'b1, 16'h8000, 16'h8000);  wait_done("s_8000_8000", 32'h40000000);
    launch(1'b1, 16'hFFFF, 16'h0001);  wait_done("s_ffff_0001", 32'hFFFFFFFF);
    launch(1'b0, 16'hFFFF, 16'h0001);  wait_done("u_ffff_0001", 32'h0000FFFF);
    launch(1'b1, 16'h8000, 16'h7FFF);  wait_done("s_8000_7fff", 32'hC0008000);
    launch(1'b0, 16'h8000, 16'h8000);  wait_done("u_8000_8000", 32'h40000000);
    launch(1'b0, 16'h0000, 16'hABCD);  wait_done("u_0_abcd", 32'h00000000);

    // Reissue: start pulses sampled at cycles 3 and 9 of an active op are ignored.
    launch(1'b0, 16'h1234, 16'h5678);
    lat = 0;
    do begin
      check("reissue busy_ready", 32'(bus_if.ready), 32'd0);
      if (lat == 2 || lat == 8) begin
        bus_if.start = 1'b1;
        bus_if.m_in  = 16'h0003;
        bus_if.q_in  = 16'h0005;
      end else begin
        bus_if.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end while (bus_if.done !== 1'b1 && lat < 40);
    bus_if.start = 1'b0;
    n_ops++;
    check("reissue latency", 32'(lat), 32'd10);
    check("reissue result", bus_if.result, 32'h06260060);
    check("reissue ready_at_done", 32'(bus_if.ready), 32'd0);
    @(posedge clk); #1;
    check("reissue ready_back", 32'(bus_if.ready), 32'd1);
    done_before = done_cnt;
    repeat (14) @(posedge clk);
    #1;
    check("reissue no_queued_done", 32'(done_cnt), 32'(done_before));

    // Reset in the middle of an operation.
    launch(1'b1, 16'h1234, 16'h0003);
    repeat (5) @(posedge clk);
    #1;
    done_before = done_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst result", bus_if.result, 32'h0);
    check("midrst ready", 32'(bus_if.ready), 32'd1);
    check("midrst done", 32'(bus_if.done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("midrst no_done", 32'(done_cnt), 32'(done_before));
    check("midrst result_idle", bus_if.result, 32'h0);
    launch(1'b1, 16'h0007, 16'hFFFD);  wait_done("s_7_m3", 32'hFFFFFFEB);

    // Random operand pairs in both modes against a reference product.
    for (int i = 0; i < 24; i++) begin
      sm = 1'(i % 2);
      m  = 16'($urandom());
      q  = 16'($urandom());
      if (sm) exp = 32'(int'($signed(m)) * int'($signed(q)));
      else    exp = 32'(32'(m) * 32'(q));
      launch(sm, m, q);
      wait_done(sm ? "rand_signed" : "rand_unsigned", exp);
    end

    check("done_count", 32'(done_cnt), 32'(n_ops));
    check("protocol_violations", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
